// File: rtl/ulpi_send.sv
// ulpi_send: link-side ULPI transmit engine for the USB3300.
// Serialises a PHY register write (TX CMD + data) or a USB packet
// (TX CMD with PID + byte stream) onto the ULPI DATA bus, honouring
// NXT, STP and DIR. All state changes on the falling edge of clk_ULPI.
//
// Ports:
//   clk_ULPI, rst                 60 MHz ULPI clock, async active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_type/addr/data/pid        0 = register write, 1 = packet
//   tx_data/valid/last/ready      packet byte stream
//   busy, done, aborted, timeout  status and 1-cycle result pulses
//   DIR, NXT                      ULPI inputs from the PHY
//   DATA_O, DATA_OE, STP          ULPI outputs to the PHY
module ulpi_send #(
  parameter int unsigned NXT_TIMEOUT = 255
) (
  input  logic       clk_ULPI,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_type,
  input  logic [5:0] cmd_addr,
  input  logic [7:0] cmd_data,
  input  logic [3:0] cmd_pid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic       timeout,
  input  logic       DIR,
  input  logic       NXT,
  output logic [7:0] DATA_O,
  output logic       DATA_OE,
  output logic       STP
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_REGD, S_PKT, S_STOP, S_DRAIN, S_WAITBUS
  } state_t;

  state_t     r_state, w_next;
  logic       r_dir_q;
  logic       r_type;
  logic [5:0] r_addr;
  logic [7:0] r_data;
  logic [3:0] r_pid;
  logic [9:0] r_cnt;
  logic       r_err, r_drain;
  logic       r_done, r_aborted, r_timeout;

  logic       w_accept, w_drive, w_tmo_hit;
  logic       w_err, w_drain;
  logic       w_done_set, w_abort_set, w_tmo_set;

  assign w_accept  = cmd_valid && cmd_ready;
  assign w_drive   = (r_state == S_CMD) || (r_state == S_REGD) || (r_state == S_PKT);
  assign w_tmo_hit = (32'(r_cnt) + 32'd1) >= NXT_TIMEOUT;

  // Turnaround: hold off a new command until DIR has been low for a full cycle.
  assign cmd_ready = (r_state == S_IDLE) && !rst && !DIR && !r_dir_q;
  assign tx_ready  = ((r_state == S_PKT) && NXT && !DIR) || (r_state == S_DRAIN);
  // Release the bus in the very cycle the PHY claims it.
  assign DATA_OE   = (w_drive && !DIR) || (r_state == S_STOP);
  assign STP       = (r_state == S_STOP);
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign aborted   = r_aborted;
  assign timeout   = r_timeout;

  always_comb begin
    DATA_O = '0;
    case (r_state)
      S_CMD:   DATA_O = r_type ? {4'b0100, r_pid} : {2'b10, r_addr};
      S_REGD:  DATA_O = r_data;
      S_PKT:   DATA_O = tx_data;
      S_STOP:  DATA_O = r_err ? 8'hFF : 8'h00;
      default: DATA_O = '0;
    endcase
  end

  always_comb begin
    w_next      = r_state;
    w_err       = r_err;
    w_drain     = r_drain;
    w_done_set  = 1'b0;
    w_abort_set = 1'b0;
    w_tmo_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next  = S_CMD;
          w_err   = 1'b0;
          w_drain = 1'b0;
        end
      end
      S_CMD: begin
        if (DIR) begin
          w_next      = S_WAITBUS;
          w_abort_set = 1'b1;
          w_drain     = r_type;
        end else if (NXT) begin
          w_next = r_type ? S_PKT : S_REGD;
        end else if (w_tmo_hit) begin
          w_next    = S_STOP;
          w_err     = 1'b1;
          w_tmo_set = 1'b1;
          w_drain   = r_type;
        end
      end
      S_REGD: begin
        if (DIR) begin
          w_next      = S_WAITBUS;
          w_abort_set = 1'b1;
          w_drain     = 1'b0;
        end else if (NXT) begin
          w_next     = S_STOP;
          w_err      = 1'b0;
          w_done_set = 1'b1;
        end
      end
      S_PKT: begin
        if (DIR) begin
          w_next      = S_WAITBUS;
          w_abort_set = 1'b1;
          w_drain     = 1'b1;
        end else if (NXT) begin
          if (!tx_valid) begin
            w_next      = S_STOP;
            w_err       = 1'b1;
            w_abort_set = 1'b1;
            w_drain     = 1'b1;
          end else if (tx_last) begin
            w_next     = S_STOP;
            w_err      = 1'b0;
            w_done_set = 1'b1;
            w_drain    = 1'b0;
          end
        end
      end
      S_STOP:    w_next = r_drain ? S_DRAIN : S_IDLE;
      S_DRAIN:   if (tx_valid && tx_last) w_next = S_IDLE;
      S_WAITBUS: if (!DIR) w_next = r_drain ? S_DRAIN : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(negedge clk_ULPI or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_dir_q   <= 1'b0;
      r_type    <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_pid     <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_drain   <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_dir_q   <= DIR;
      r_err     <= w_err;
      r_drain   <= w_drain;
      r_done    <= w_done_set;
      r_aborted <= w_abort_set;
      r_timeout <= w_tmo_set;
      if (w_accept) begin
        r_type <= cmd_type;
        r_addr <= cmd_addr;
        r_data <= cmd_data;
        r_pid  <= cmd_pid;
        r_cnt  <= '0;
      end else if (r_state == S_CMD && r_cnt != '1) begin
        r_cnt <= r_cnt + 10'd1;
      end
    end
  end

endmodule
